// File: rtl/traffic_pkg.sv
// Shared types for the two-road traffic-light controller.
//   light_t    : lamp-head encoding driven on La/Lb (2'b11 is never used)
//   tl_state_t : controller state; S0 = A green, S1 = A yellow,
//                S2 = B green, S3 = B yellow
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    RED    = 2'b10
  } light_t;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } tl_state_t;

endpackage

// File: rtl/fsm_1_if.sv
// Sensor/lamp bundle between the road side and the controller.
//   Ta, Tb : traffic sensors, 1 = cars present (synchronous to clk)
//   La, Lb : lamp heads for street A / street B
// Modports:
//   slave  : the controller (reads sensors, drives lamps)
//   master : the road side / environment (drives sensors, reads lamps)
// There is no valid/ready handshake on this bundle: sensors are level
// inputs sampled every rising edge and lamps are continuously valid levels.
interface fsm_1_if;
  import traffic_pkg::*;

  logic   Ta;
  logic   Tb;
  light_t La;
  light_t Lb;

  modport slave  (input  Ta, Tb, output La, Lb);
  modport master (output Ta, Tb, input  La, Lb);

endinterface

// File: rtl/fsm_1_yellow_timer.sv
// Yellow-phase timer for the traffic controller.
//   clk  : system clock
//   rst  : synchronous active-high reset, clears the count
//   run  : high while the controller sits in a yellow state
//   done : high in the last cycle of the yellow phase
// The count sits at 0 whenever run is low, so it is already cleared on
// entry to a yellow state. It restarts at 0 after done, so it never wraps.
module fsm_1_yellow_timer #(
  parameter int YELLOW_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic done
);

  localparam int CW = $clog2(YELLOW_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(YELLOW_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !run || done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign done = (cnt == LAST);

endmodule

// File: rtl/fsm_1.sv
// Two-road traffic-light controller (Moore FSM).
// Street A is the main road, street B the side road. A keeps green while
// it has traffic, then goes through yellow to give green to B; B keeps
// green while it has traffic, then goes through yellow back to A.
//   clk       : system clock, all state changes on the rising edge
//   rst       : synchronous active-high reset -> S0 (A green, B red)
//   bus       : fsm_1_if.slave, sensors Ta/Tb in, lamps La/Lb out
//   dbg_state : current state register, for observation only
// Lamps are decoded from the state register alone, so sensor glitches
// can never reach the lamp heads.
module fsm_1
  import traffic_pkg::*;
#(
  parameter int YELLOW_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  fsm_1_if.slave      bus,
  output tl_state_t   dbg_state
);

  tl_state_t state;
  tl_state_t next_state;
  logic      yellow_run;
  logic      yellow_done;

  fsm_1_yellow_timer #(
    .YELLOW_CYCLES(YELLOW_CYCLES)
  ) u_yellow_timer (
    .clk  (clk),
    .rst  (rst),
    .run  (yellow_run),
    .done (yellow_done)
  );

  assign yellow_run = (state == S1) || (state == S3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S0;
    end else begin
      state <= next_state;
    end
  end

  // Sensors only matter in the green states; yellow is purely timed.
  always_comb begin
    next_state = S0;
    case (state)
      S0:      next_state = bus.Ta ? S0 : S1;
      S1:      next_state = yellow_done ? S2 : S1;
      S2:      next_state = bus.Tb ? S2 : S3;
      S3:      next_state = yellow_done ? S0 : S3;
      default: next_state = S0;
    endcase
  end

  // Defaults to all-red so any undecoded state fails safe.
  always_comb begin
    bus.La = RED;
    bus.Lb = RED;
    case (state)
      S0:      bus.La = GREEN;
      S1:      bus.La = YELLOW;
      S2:      bus.Lb = GREEN;
      S3:      bus.Lb = YELLOW;
      default: begin
        bus.La = RED;
        bus.Lb = RED;
      end
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_fsm_1.sv
// Self-checking bench for fsm_1: a YELLOW_CYCLES=1 instance driven from a
// vector table, and a YELLOW_CYCLES=3 instance driven by hand sequences.
module tb_fsm_1;
  import traffic_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic rst3;
  always #5 clk = ~clk;

  fsm_1_if bus  ();
  fsm_1_if bus3 ();
  tl_state_t st;
  tl_state_t st3;

  fsm_1 #(.YELLOW_CYCLES(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (st)
  );

  fsm_1 #(.YELLOW_CYCLES(3)) dut3 (
    .clk       (clk),
    .rst       (rst3),
    .bus       (bus3),
    .dbg_state (st3)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic safe(input logic [1:0] la, input logic [1:0] lb);
    return !(la != 2'b10 && lb != 2'b10) && la != 2'b11 && lb != 2'b11;
  endfunction

  // One rising edge, then sample 1 time unit later and check lamp safety.
  task automatic step();
    @(posedge clk);
    #1;
    chk("safety_yc1", {1'b0, safe(bus.La, bus.Lb)}, 2'b01);
    chk("safety_yc3", {1'b0, safe(bus3.La, bus3.Lb)}, 2'b01);
  endtask

  task automatic chk3(input string name, input logic [1:0] la, input logic [1:0] lb,
                      input logic [1:0] s);
    chk({name, "_la"}, bus3.La, la);
    chk({name, "_lb"}, bus3.Lb, lb);
    chk({name, "_st"}, st3, s);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic       ta;
    logic       tb;
    logic [1:0] la;
    logic [1:0] lb;
    logic [1:0] st;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  initial begin
    // Expected lamps/state after the edge that samples the row's inputs.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00}; // reset -> S0
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00}; // A busy, hold S0
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 2'b00, 2'b10, 2'b00};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 2'b00, 2'b10, 2'b00};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b01}; // A released -> S1
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10}; // -> S2
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10}; // B holds
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 2'b10, 2'b00, 2'b10};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b11}; // B released -> S3
    vecs[11] = '{1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00}; // sensors ignored in S3
    vecs[12] = '{1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b01}; // -> S1
    vecs[13] = '{1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10}; // sensors ignored in S1
    vecs[14] = '{1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b11}; // -> S3
    vecs[15] = '{1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00}; // -> S0
    vecs[16] = '{1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b01}; // -> S1
    vecs[17] = '{1'b1, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00}; // reset from S1
    vecs[18] = '{1'b0, 1'b0, 1'b1, 2'b01, 2'b10, 2'b01}; // -> S1
    vecs[19] = '{1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10}; // -> S2
    vecs[20] = '{1'b1, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00}; // reset from S2
    vecs[21] = '{1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00}; // hold S0
  end

  // ---------------- driver / test sequence ----------------
  initial begin
    rst     = 1'b1;
    bus.Ta  = 1'b1;
    bus.Tb  = 1'b0;
    rst3    = 1'b1;
    bus3.Ta = 1'b1;
    bus3.Tb = 1'b0;
    #1;

    // Table-driven run on the YELLOW_CYCLES=1 instance.
    for (int i = 0; i < NV; i++) begin
      rst    = vecs[i].rst;
      bus.Ta = vecs[i].ta;
      bus.Tb = vecs[i].tb;
      step();
      chk($sformatf("v%0d_la", i), bus.La, vecs[i].la);
      chk($sformatf("v%0d_lb", i), bus.Lb, vecs[i].lb);
      chk($sformatf("v%0d_st", i), st, vecs[i].st);
    end
    rst    = 1'b0;
    bus.Ta = 1'b1;
    bus.Tb = 1'b0;

    // YELLOW_CYCLES=3 instance: reset state, then hold with A busy.
    chk3("yc3_rst", 2'b00, 2'b10, 2'b00);
    rst3 = 1'b0;
    step();
    chk3("yc3_hold0", 2'b00, 2'b10, 2'b00);
    step();
    chk3("yc3_hold1", 2'b00, 2'b10, 2'b00);

    // A released: three yellow cycles, toggling sensors, then B green.
    bus3.Ta = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk3($sformatf("yc3_s1_%0d", k), 2'b01, 2'b10, 2'b01);
      bus3.Ta = k[0];
      bus3.Tb = ~k[0];
    end
    bus3.Tb = 1'b1;
    step();
    chk3("yc3_s2", 2'b10, 2'b00, 2'b10);

    // B released: three yellow cycles for B, sensors toggling, then A green.
    bus3.Tb = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk3($sformatf("yc3_s3_%0d", k), 2'b10, 2'b01, 2'b11);
      bus3.Ta = ~k[0];
      bus3.Tb = k[0];
    end
    bus3.Ta = 1'b1;
    step();
    chk3("yc3_back_s0", 2'b00, 2'b10, 2'b00);

    // Reset in the middle of yellow, then a full-length yellow must follow.
    bus3.Ta = 1'b0;
    step();
    chk3("yc3_mid_a", 2'b01, 2'b10, 2'b01);
    step();
    chk3("yc3_mid_b", 2'b01, 2'b10, 2'b01);
    rst3 = 1'b1;
    step();
    chk3("yc3_mid_rst", 2'b00, 2'b10, 2'b00);
    rst3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk3($sformatf("yc3_after_rst_%0d", k), 2'b01, 2'b10, 2'b01);
    end
    bus3.Tb = 1'b0;
    step();
    chk3("yc3_after_rst_s2", 2'b10, 2'b00, 2'b10);
    step();
    chk3("yc3_after_rst_s3", 2'b10, 2'b01, 2'b11);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
